bus_condition_gen: RTL
======================

Name: bus_condition_gen

Overview:
- Transmit-side counterpart of the controller's SCL/SDA edge detection: drives START, Repeated START and STOP conditions onto the open-drain SCL/SDA lines.
- Sequences each condition with programmable setup/hold counts, and advances only once the sensed line actually reaches the driven level. This honours clock stretching and detects lost bus ownership.
- Sits between the controller FSM (command handshake) and the PHY output/input synchronisers.

Parameters:
- CNTR_W, 20, width of all timing counts and the internal counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command request
- cmd_i  in  2  bus_cond_e: START=0, RSTART=1, STOP=2; 3 is reserved
- cmd_ready_o  out  1  high only in IDLE
- done_o  out  1  one-cycle pulse when the condition completes
- arb_lost_o  out  1  one-cycle pulse when SDA is seen low while released
- timeout_o  out  1  one-cycle pulse on SCL stretch timeout (optional feature)
- scl_i, sda_i  in  1 each  synchronised sensed line levels
- scl_o, sda_o  out  1 each  registered open-drain drive; 1 = release, 0 = pull low
- t_su_sta_i, t_hd_sta_i, t_su_sto_i, t_low_i  in  CNTR_W each  timing counts in clk cycles
- timeout_i  in  CNTR_W  stretch limit

Behaviour:
- Reset values:
  - scl_o=1, sda_o=1, cmd_ready_o=1.
  - done_o=0, arb_lost_o=0, timeout_o=0.
  - FSM in IDLE; counter=0.
- Handshake:
  - A command is accepted when cmd_valid_i & cmd_ready_o.
  - cmd_ready_o drops the next cycle and stays low until the FSM returns to IDLE.
  - Reserved cmd_i=3 is accepted, ignored, and returns to IDLE with no pulse.
- Timed wait rule (every timed state):
  - Counter clears on state entry.
  - Counter increments only while the sensed condition holds; it clears whenever the condition drops.
  - The state exits in the cycle where counter >= count and the condition holds.
  - A count of 0 therefore means one cycle in the state, provided the condition holds.
- States and transitions:
  - IDLE: hold the last scl_o/sda_o. START -> SU_STA. RSTART -> RS_LOW. STOP -> SP_LOW.
  - RS_LOW: scl_o=0, sda_o=1. Unconditional wait of t_low_i, then SU_STA.
  - SU_STA: scl_o=1, sda_o=1. Condition is scl_i & sda_i; wait t_su_sta_i, then HD_STA. If scl_i=1 and sda_i=0: pulse arb_lost_o, go to IDLE, keep both released.
  - HD_STA: sda_o=0, scl_o=1. Wait t_hd_sta_i, then CLAIM.
  - CLAIM: scl_o=0, sda_o=0 (bus held). Pulse done_o, go to IDLE.
  - SP_LOW: scl_o=0, sda_o=0. Wait t_low_i, then SU_STO.
  - SU_STO: scl_o=1, sda_o=0. Condition is scl_i; wait t_su_sto_i, then SP_REL.
  - SP_REL: sda_o=1. One cycle, then CHECK.
  - CHECK: if sda_i=1, pulse done_o; otherwise pulse arb_lost_o. Go to IDLE with both lines released.
- Latency, START from a free bus with all counts N: done_o asserts N+1 cycles in SU_STA, plus N+1 in HD_STA, plus 1, all after acceptance.
- Boundaries:
  - The counter saturates at all-ones; it never wraps.
  - A new cmd_valid_i during a sequence is not accepted.
  - rst_i mid-sequence releases both lines immediately (asynchronous) and returns to IDLE.
  - Pulses are never simultaneous: arb_lost_o takes priority and suppresses done_o.

Optional Feature:
- Macro: BUS_COND_TIMEOUT_EN.
- With the macro:
  - A second counter runs while in SU_STA or SU_STO with scl_o=1 and scl_i=0.
  - Reaching timeout_i pulses timeout_o and goes to IDLE with both lines released, no done_o.
  - timeout_i=0 disables the check.
- Without the macro:
  - Stretch waits are unbounded.
  - timeout_o is tied 0 and timeout_i is unused; both ports remain present.

Decomposition:
- controller_pkg holds:
  - typedef enum logic [1:0] bus_cond_e (BUS_COND_START, BUS_COND_RSTART, BUS_COND_STOP).
  - The state enum bus_cond_state_e.
- One sub-module, bus_cond_timer:
  - Inputs: clear, cond, count.
  - Output: expired.
  - Behaviour: saturating counter implementing the timed wait rule, instantiated once and shared by all states.

Test Plan:
- START, bus free, all counts 3: sda_o falls 4 cycles after entering SU_STA; scl_o falls 4 cycles later; done_o pulses once; final scl_o=0, sda_o=0.
- STOP from held bus, t_low=2, t_su_sto=5, scl_i held low 10 extra cycles (stretch): sda_o releases only 6 cycles after scl_i rises; CHECK sees sda_i=1 -> done_o.
- RSTART, t_low=4: scl_o low for 5 cycles with sda_o=1, then the START sequence; a single done_o pulse.
- START with sda_i forced 0 while scl_i=1 in SU_STA: arb_lost_o pulses, no done_o, both lines released, cmd_ready_o=1 next cycle.
- All counts 0: START completes with exactly 1 cycle each in SU_STA, HD_STA and CLAIM; cmd_valid_i held during the sequence is accepted only after return to IDLE.
- rst_i asserted during HD_STA: scl_o=sda_o=1 asynchronously, no pulses. With BUS_COND_TIMEOUT_EN, timeout_i=8 and scl_i stuck low in SU_STO: timeout_o pulses after 8 cycles.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared types for the controller slice: bus condition commands and the
// condition-generator state encoding.
package controller_pkg;

  typedef enum logic [1:0] {
    BUS_COND_START  = 2'd0,
    BUS_COND_RSTART = 2'd1,
    BUS_COND_STOP   = 2'd2
  } bus_cond_e;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RS_LOW = 4'd1,
    ST_SU_STA = 4'd2,
    ST_HD_STA = 4'd3,
    ST_CLAIM  = 4'd4,
    ST_SP_LOW = 4'd5,
    ST_SU_STO = 4'd6,
    ST_SP_REL = 4'd7,
    ST_CHECK  = 4'd8,
    ST_NOP    = 4'd9
  } bus_cond_state_e;

endpackage

// File: rtl/bus_condition_gen_if.sv
// Command handshake and open-drain line bundle between the controller FSM,
// the condition generator and the PHY synchronisers.
interface bus_condition_gen_if;
  // cmd is transferred on a clock edge where cmd_valid and cmd_ready are both
  // high; cmd_valid/cmd must stay stable until then. done, arb_lost and
  // timeout are single-cycle pulses, never more than one at a time.
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       done;
  logic       arb_lost;
  logic       timeout;
  logic       scl_o;
  logic       sda_o;
  logic       scl_i;
  logic       sda_i;

  modport master (
    output cmd_valid, cmd,
    input  cmd_ready, done, arb_lost, timeout
  );

  modport slave (
    input  cmd_valid, cmd, scl_i, sda_i,
    output cmd_ready, done, arb_lost, timeout, scl_o, sda_o
  );
endinterface

// File: rtl/bus_condition_gen_timer.sv
// Saturating wait counter shared by every timed state: counts while the
// sensed condition holds, restarts whenever it drops or on clear.
module bus_cond_timer #(
  parameter int CNTR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              cond_i,
  input  logic [CNTR_W-1:0] count_i,
  output logic              expired_o
);

  logic [CNTR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !cond_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of 0 exits after a single cycle with the condition true.
  assign expired_o = cond_i && (cnt_q >= count_i);

endmodule

// File: rtl/bus_condition_gen.sv
// Drives START / Repeated START / STOP onto open-drain SCL/SDA, pacing each
// step on the sensed line levels. BUS_COND_TIMEOUT_EN adds an SCL stretch limit.
module bus_condition_gen
  import controller_pkg::*;
#(
  parameter int CNTR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  input  logic [1:0]        cmd_i,
  output logic              cmd_ready_o,
  output logic              done_o,
  output logic              arb_lost_o,
  output logic              timeout_o,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              scl_o,
  output logic              sda_o,
  input  logic [CNTR_W-1:0] t_su_sta_i,
  input  logic [CNTR_W-1:0] t_hd_sta_i,
  input  logic [CNTR_W-1:0] t_su_sto_i,
  input  logic [CNTR_W-1:0] t_low_i,
  input  logic [CNTR_W-1:0] timeout_i
);

  bus_cond_state_e   state_q, state_d;
  logic              scl_q, scl_d, sda_q, sda_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d, arb_q, arb_d, to_q, to_d;
  logic              tmr_timed, tmr_cond, tmr_expired, tmr_clear, to_hit;
  logic [CNTR_W-1:0] tmr_count;

  always_comb begin
    tmr_timed = 1'b0;
    tmr_cond  = 1'b0;
    tmr_count = '0;
    unique case (state_q)
      ST_RS_LOW, ST_SP_LOW: begin
        tmr_timed = 1'b1;
        tmr_cond  = 1'b1;
        tmr_count = t_low_i;
      end
      ST_SU_STA: begin
        tmr_timed = 1'b1;
        tmr_cond  = scl_i && sda_i;
        tmr_count = t_su_sta_i;
      end
      ST_HD_STA: begin
        tmr_timed = 1'b1;
        tmr_cond  = 1'b1;
        tmr_count = t_hd_sta_i;
      end
      ST_SU_STO: begin
        tmr_timed = 1'b1;
        tmr_cond  = scl_i;
        tmr_count = t_su_sto_i;
      end
      default: ;
    endcase
  end

  // Restarting on every exit guarantees a zero count on entry to the next state.
  assign tmr_clear = !tmr_timed || tmr_expired;

  bus_cond_timer #(.CNTR_W(CNTR_W)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (tmr_clear),
    .cond_i    (tmr_cond),
    .count_i   (tmr_count),
    .expired_o (tmr_expired)
  );

`ifdef BUS_COND_TIMEOUT_EN
  logic              stretch;
  logic [CNTR_W-1:0] to_cnt_q, to_cnt_d;

  assign stretch = ((state_q == ST_SU_STA) || (state_q == ST_SU_STO)) && scl_q && !scl_i;

  always_comb begin
    to_cnt_d = '0;
    if (stretch) begin
      to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + CNTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // Fires on the timeout_i-th consecutive stretched cycle.
  assign to_hit = stretch && (timeout_i != '0) &&
                  (({1'b0, to_cnt_q} + (CNTR_W+1)'(1)) >= {1'b0, timeout_i});
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign to_hit         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    done_d  = 1'b0;
    arb_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          case (cmd_i)
            BUS_COND_START:  begin state_d = ST_SU_STA; scl_d = 1'b1; sda_d = 1'b1; end
            BUS_COND_RSTART: begin state_d = ST_RS_LOW; scl_d = 1'b0; sda_d = 1'b1; end
            BUS_COND_STOP:   begin state_d = ST_SP_LOW; scl_d = 1'b0; sda_d = 1'b0; end
            default:         state_d = ST_NOP;
          endcase
        end
      end
      ST_RS_LOW: if (tmr_expired) begin state_d = ST_SU_STA; scl_d = 1'b1; sda_d = 1'b1; end
      ST_SU_STA: begin
        // Someone else holds SDA low while SCL is high: the bus is not ours.
        if (scl_i && !sda_i) begin
          state_d = ST_IDLE; arb_d = 1'b1; scl_d = 1'b1; sda_d = 1'b1;
        end else if (to_hit) begin
          state_d = ST_IDLE; to_d = 1'b1; scl_d = 1'b1; sda_d = 1'b1;
        end else if (tmr_expired) begin
          state_d = ST_HD_STA; sda_d = 1'b0;
        end
      end
      ST_HD_STA: if (tmr_expired) begin state_d = ST_CLAIM; scl_d = 1'b0; end
      ST_CLAIM:  begin state_d = ST_IDLE; done_d = 1'b1; end
      ST_SP_LOW: if (tmr_expired) begin state_d = ST_SU_STO; scl_d = 1'b1; end
      ST_SU_STO: begin
        if (to_hit) begin
          state_d = ST_IDLE; to_d = 1'b1; scl_d = 1'b1; sda_d = 1'b1;
        end else if (tmr_expired) begin
          state_d = ST_SP_REL; sda_d = 1'b1;
        end
      end
      ST_SP_REL: state_d = ST_CHECK;
      ST_CHECK: begin
        state_d = ST_IDLE;
        scl_d   = 1'b1;
        sda_d   = 1'b1;
        done_d  = sda_i;
        arb_d   = !sda_i;
      end
      ST_NOP:  state_d = ST_IDLE;
      default: begin state_d = ST_IDLE; scl_d = 1'b1; sda_d = 1'b1; end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      arb_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      arb_q   <= arb_d;
      to_q    <= to_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign done_o      = done_q;
  assign arb_lost_o  = arb_q;
  assign timeout_o   = to_q;
  assign scl_o       = scl_q;
  assign sda_o       = sda_q;

endmodule
